// File: rtl/demux_pkg.sv
// Shared helpers and default sizes for the 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int N_CH_DEF   = 8;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // An index field always needs at least one bit, even for a single entry.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel FIFO with non-power-of-2 depth support; head reads as zero when empty.
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int PTR_W = sel_width(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO refuses a push even if it pops in the same cycle.
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/demux_stream_1xn.sv
// 1-to-N valid/ready stream demultiplexer with per-channel FIFOs, broadcast,
// and a saturating counter of words addressed to nonexistent channels.
module demux_stream_1xn
    import demux_pkg::*;
#(
    parameter int  N_CH   = N_CH_DEF,
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  DROP_W = DROP_W_DEF,
    localparam int SEL_W  = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   bcast,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [DROP_W-1:0]      drop_cnt
);

    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_empty;
    logic [N_CH-1:0]   w_sel_hit;
    logic [N_CH-1:0]   w_push;
    logic              w_hit_any;
    logic              w_accept;
    logic              w_drop;
    logic [DROP_W-1:0] r_drop_cnt;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // One-hot decode; all-zero when in_sel addresses no existing channel.
    always_comb begin
        w_sel_hit = '0;
        for (int k = 0; k < N_CH; k++) w_sel_hit[k] = (in_sel == SEL_W'(k));
    end

    assign w_hit_any = |w_sel_hit;

    always_comb begin
        if (bcast)          in_ready = &(~w_full);
        else if (w_hit_any) in_ready = |(w_sel_hit & ~w_full);
        else                in_ready = 1'b1;
    end

    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & ~bcast & ~w_hit_any;

    always_comb begin
        w_push = '0;
        if (w_accept) w_push = bcast ? {N_CH{1'b1}} : w_sel_hit;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        demux_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_data  (in_data),
            .i_pop   (out_ready[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_head  (out_data[g*DATA_W +: DATA_W])
        );
    end

    assign out_valid = ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_drop_cnt <= '0;
        else if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
    end

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed bench for demux_stream_1xn: an 8-channel instance plus a 6-channel one for drops.
module tb_demux_stream_1xn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, bcast;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid, out_ready;
    logic [63:0] out_data;
    logic [7:0]  drop_cnt;

    logic        in_valid6, in_ready6, bcast6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic [5:0]  out_valid6, out_ready6;
    logic [47:0] out_data6;
    logic [7:0]  drop_cnt6;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] bp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    demux_stream_1xn #(.N_CH(8), .DATA_W(8), .DEPTH(4), .DROP_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .bcast(bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    demux_stream_1xn #(.N_CH(6), .DATA_W(8), .DEPTH(4), .DROP_W(8)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
        .in_sel(in_sel6), .bcast(bcast6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .drop_cnt(drop_cnt6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ch(input int k);
        return out_data[k*8 +: 8];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_sel = 0; in_data = 0; bcast = 0; out_ready = 0;
        in_valid6 = 0; in_sel6 = 0; in_data6 = 0; bcast6 = 0; out_ready6 = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        #11 rst_n = 1'b1;
        tick;

        // Route a single word to channel 3
        in_valid = 1; in_sel = 3; in_data = 8'hA5;
        #1;
        check("route_in_ready", 64'(in_ready), 64'h1);
        check("route_no_passthru", 64'(out_valid), 64'h0);
        tick;
        in_valid = 0;
        #1;
        check("route_valid", 64'(out_valid), 64'h08);
        check("route_data", 64'(ch(3)), 64'hA5);
        check("route_others_zero", out_data & ~(64'hFF << 24), 64'h0);
        out_ready = 8'h08;
        tick;
        out_ready = 0;
        #1;
        check("route_pop", 64'(out_valid), 64'h0);

        // Backpressure on channel 5
        in_sel = 5;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = bp_words[i];
            #1;
            check("bp_ready", 64'(in_ready), 64'h1);
            tick;
        end
        in_data = 8'h55;
        #1;
        check("bp_stall", 64'(in_ready), 64'h0);
        tick;
        in_valid = 0;
        #1;
        check("bp_hold_head", 64'(ch(5)), 64'h11);
        in_sel = 2;
        #1;
        check("bp_other_ready", 64'(in_ready), 64'h1);
        out_ready = 8'h20;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain", 64'(ch(5)), 64'(bp_words[i]));
            tick;
        end
        out_ready = 0;
        #1;
        check("bp_empty", 64'(out_valid), 64'h0);

        // Broadcast, then blocked broadcast with channel 6 full
        bcast = 1; in_data = 8'h3C; in_valid = 1;
        #1;
        check("bc_ready", 64'(in_ready), 64'h1);
        tick;
        in_valid = 0; bcast = 0;
        #1;
        check("bc_valid", 64'(out_valid), 64'hFF);
        check("bc_data", out_data, {8{8'h3C}});
        in_sel = 6; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h60 + i);
            tick;
        end
        in_valid = 0;
        #1;
        check("bc_ch6_full", 64'(in_ready), 64'h0);
        bcast = 1; in_data = 8'h77; in_valid = 1;
        #1;
        check("bc_blocked", 64'(in_ready), 64'h0);
        tick;
        in_valid = 0; bcast = 0; out_ready = 8'h01;
        #1;
        check("bc_ch0_head", 64'(ch(0)), 64'h3C);
        tick;
        out_ready = 0;
        #1;
        check("bc_none_written", 64'(out_valid), 64'hFE);
        check("bc_ch6_head", 64'(ch(6)), 64'h3C);

        // Out-of-range drops on the 6-channel instance
        in_sel6 = 7; in_valid6 = 1;
        #1;
        check("drop_ready", 64'(in_ready6), 64'h1);
        tick;
        check("drop_no_valid", 64'(out_valid6), 64'h0);
        check("drop_cnt1", 64'(drop_cnt6), 64'h1);
        repeat (253) tick;
        check("drop_cnt254", 64'(drop_cnt6), 64'd254);
        repeat (46) tick;
        check("drop_sat", 64'(drop_cnt6), 64'd255);
        in_valid6 = 0;
        check("drop_still_no_valid", 64'(out_valid6), 64'h0);

        // Mid-clock asynchronous reset with data and drops pending
        bcast = 1;
        #1;
        check("arst_pre_ready", 64'(in_ready), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_data", out_data, 64'h0);
        check("arst_drop_cnt6", 64'(drop_cnt6), 64'h0);
        check("arst_in_ready", 64'(in_ready), 64'h1);
        #1 rst_n = 1'b1;
        bcast = 0;
        tick;

        // Reset with every channel holding two words
        in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 2; j++) begin
                in_sel = 3'(k); in_data = 8'(k*16 + j + 1);
                tick;
            end
        end
        in_valid = 0;
        #1;
        check("mf_all_valid", 64'(out_valid), 64'hFF);
        check("mf_ch7_head", 64'(ch(7)), 64'h71);
        #2 rst_n = 1'b0;
        #1;
        check("mf_rst_valid", 64'(out_valid), 64'h0);
        check("mf_rst_data", out_data, 64'h0);
        #1 rst_n = 1'b1;
        tick;
        in_valid = 1; in_sel = 1; in_data = 8'h5A;
        tick;
        in_valid = 0;
        #1;
        check("mf_single_valid", 64'(out_valid), 64'h02);
        check("mf_single_data", 64'(ch(1)), 64'h5A);
        out_ready = 8'h02;
        tick;
        out_ready = 0;
        #1;
        check("mf_alone", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
